// File: rtl/audio_pkg.sv
// Shared types and defaults for the PWM audio output stage.
package audio_pkg;

    typedef enum logic [1:0] {
        MUTED = 2'd0,
        PLAY  = 2'd1,
        RAMP  = 2'd2
    } mute_state_t;

    localparam int unsigned DEFAULT_N = 8;

endpackage

// File: rtl/pwm_audio_out_if.sv
// Sample handshake, mute control and audio outputs of pwm_audio_out.
interface pwm_audio_out_if
    import audio_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
);

    logic [N-1:0] dac_count;
    logic         sample_valid;
    logic         sample_ready;
    logic         mute;
    logic         pwm;
    logic         underrun;
    logic         period_start;

    modport master (
        output dac_count, sample_valid, mute,
        input  sample_ready, pwm, underrun, period_start
    );

    modport slave (
        input  dac_count, sample_valid, mute,
        output sample_ready, pwm, underrun, period_start
    );

endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler: tick is high for one clock out of every DIV (always high when DIV=1).
module pwm_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (pre == LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == LAST);

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: one-deep sample buffer, period-aligned duty updates, mute and underrun.
// Define PWM_MUTE_RAMP_EN to fade the duty down by RAMP_STEP per period on mute.
module pwm_audio_out
    import audio_pkg::*;
#(
    parameter int unsigned N         = DEFAULT_N,
    parameter int unsigned DIV       = 1,
    parameter int unsigned RAMP_STEP = 1
) (
    input logic            clk,
    input logic            rst,
    pwm_audio_out_if.slave bus
);

    if (DIV == 0 || RAMP_STEP > (2**N - 1)) begin : g_cfg_check
        $error("pwm_audio_out: DIV must be >= 1 and RAMP_STEP must fit in N bits");
    end

    logic         tick;
    logic         boundary;
    logic         accept;
    logic [N-1:0] pwm_cnt;
    logic [N-1:0] active_duty;
    logic [N-1:0] pending;
    logic         pending_full;
    logic         pwm_q;
    logic         underrun_q;
    logic         period_start_q;
    mute_state_t  state;

    pwm_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign boundary = tick && (pwm_cnt == '1);
    assign accept   = bus.sample_valid && !pending_full;

    assign bus.sample_ready = !pending_full;
    assign bus.pwm          = pwm_q;
    assign bus.underrun     = underrun_q;
    assign bus.period_start = period_start_q;

`ifdef PWM_MUTE_RAMP_EN
    localparam logic [N-1:0] STEP = N'(RAMP_STEP);
    logic [N-1:0] ramped;
    assign ramped = (active_duty > STEP) ? active_duty - STEP : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= MUTED;
            active_duty    <= '0;
            pending        <= '0;
            pending_full   <= 1'b0;
            pwm_q          <= 1'b0;
            underrun_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pwm_q          <= (state != MUTED) && (pwm_cnt < active_duty);
            underrun_q     <= 1'b0;
            period_start_q <= boundary;

            if (boundary) begin
                // Every state either consumes or discards the buffered sample here.
                pending_full <= 1'b0;
                case (state)
                    MUTED: begin
                        if (!bus.mute) begin
                            state <= PLAY;
                            if (pending_full) active_duty <= pending;
                        end
                    end
                    PLAY: begin
                        if (bus.mute) begin
`ifdef PWM_MUTE_RAMP_EN
                            active_duty <= ramped;
                            state       <= (ramped == '0) ? MUTED : RAMP;
`else
                            state <= MUTED;
`endif
                        end else if (pending_full) begin
                            active_duty <= pending;
                        end else begin
                            underrun_q <= 1'b1;
                        end
                    end
`ifdef PWM_MUTE_RAMP_EN
                    RAMP: begin
                        if (!bus.mute) begin
                            state <= PLAY;
                            if (pending_full) active_duty <= pending;
                        end else begin
                            active_duty <= ramped;
                            state       <= (ramped == '0) ? MUTED : RAMP;
                        end
                    end
`endif
                    default: state <= MUTED;
                endcase
            end

            // A transfer on the boundary cycle lands after the drain and plays next period.
            if (accept) begin
                pending      <= bus.dac_count;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Audio output stage at the far end of the sound generator's DAC-count interface: accepts N-bit sample codes through a valid/ready handshake and renders them as a 1-bit PWM stream on the speaker pin. The block double-buffers one sample, loads it into the active duty register only at PWM period boundaries, and owns muting and underrun reporting. It sits between the sound generator and the board's audio pin.

## Interface
- N, 8: sample/duty width; PWM period = 2^N ticks
- DIV, 1: clocks per PWM tick (≥1)
- RAMP_STEP, 1: duty decrement per period while ramping (`PWM_MUTE_RAMP_EN` only)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- dacCount_i  input  N  sample code (duty)
- sampleValid_i  input  1  dacCount_i valid this cycle
- sampleReady_o  output  1  pending buffer empty; transfer on valid && ready
- mute_i  input  1  level; mute request
- pwm_o  output  1  registered PWM output
- underrun_o  output  1  one-cycle pulse: boundary reached while playing with no pending sample
- periodStart_o  output  1  one-cycle pulse at each period boundary

## Operation
- Tick generator: tick asserts once every DIV clocks (every clock when DIV=1).
- pwmCnt (N bits) increments on tick, wraps 2^N−1 → 0. Boundary = tick with pwmCnt == 2^N−1.
- pwm_o <= (pwmCnt < activeDuty) when in PLAY/RAMP; 0 in MUTED. Duty 0 → always low; duty 2^N−1 → high 2^N−1 of 2^N ticks.
- Pending buffer: one N-bit entry plus full flag. sampleReady_o = !pendingFull (registered state, no combinational path from valid).
- At boundary: if pendingFull → activeDuty <= pending, pendingFull <= 0; else activeDuty holds and underrun_o pulses (PLAY only).
- Valid at the boundary cycle with pending empty: sample enters pending and plays in the following period, not the current one.
- State machine (states MUTED, PLAY, RAMP; transitions only at boundaries):
  - MUTED: pending still drained and discarded; no underrun; !mute_i → PLAY.
  - PLAY: mute_i → RAMP (macro on) or MUTED (macro off).
  - RAMP: activeDuty <= max(activeDuty − RAMP_STEP, 0), pending drained and discarded; duty reaches 0 → MUTED; !mute_i → PLAY (loads pending if present, else holds).
- Arithmetic: ramp subtraction saturates at 0, no wrap.

## Timing
- Reset: pwmCnt 0, prescaler 0, activeDuty 0, pendingFull 0, sampleReady_o 1, pwm_o 0, underrun_o 0, periodStart_o 0, state MUTED.
- pwm_o lags pwmCnt by one clock.
- Handshake-to-audio latency: sample accepted in period k appears in period k+1.
- periodStart_o and underrun_o assert in the cycle after the boundary tick, for exactly one clock.
- rst mid-period: immediate return to reset values; pending sample is lost.
- Simultaneous valid and boundary with pending full: no accept (ready low); buffer drains; ready rises next cycle.

## Configuration
- `PWM_MUTE_RAMP_EN` defined: RAMP state present; mute fades duty by RAMP_STEP per period (pop-free).
- Undefined: no RAMP state; PLAY → MUTED directly at boundary, pwm_o forced low from the next period; RAMP_STEP unused.

## Structure
- audio_pkg: enum typedef for mute states (MUTED, PLAY, RAMP), default N constant.
- Sub-module pwm_tick_gen: DIV prescaler producing tick; everything else in pwm_audio_out.

## Test plan
- Reset, mute_i=0, N=8, DIV=1, push 0x40 once → first boundary enters PLAY; next period pwm_o high exactly 64 of 256 clocks; underrun_o pulses at every later boundary.
- Stream 0x00, 0xFF, 0x80 one per period → high counts 0, 255, 128 in consecutive periods; no underrun.
- Push 0x10 then hold valid with 0x20 → ready drops after first accept; 0x20 accepted the cycle after the boundary; no sample lost.
- Macro on, RAMP_STEP=16, playing 0x40, assert mute_i → high counts 48, 32, 16, 0, then MUTED; no underrun in RAMP/MUTED.
- Macro off, same stimulus → pwm_o stays low from the period after the boundary.
- Assert rst mid-period with pending full → pwm_o 0, sampleReady_o 1, state MUTED immediately.
